// File: rtl/dcfifo_pkg.sv
// Shared types for the single-clock dcfifo: the per-edge operation decode
// used by the pointer/count logic.
package dcfifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_WRRD = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic wr, input logic rd);
    return fifo_op_e'({rd, wr});
  endfunction

endpackage

// File: rtl/dcfifo_ram.sv
// Simple dual-port register array: one write port and one registered read port.
// Optional write-through forwards same-edge write data to the read register.
module dcfifo_ram #(
  parameter int width         = 36,
  parameter int depth         = 4,
  parameter int addr_w        = 2,
  parameter bit write_through = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [addr_w-1:0] wr_addr,
  input  logic [width-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [addr_w-1:0] rd_addr,
  output logic [width-1:0]  rd_data
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register is cleared on reset; the array itself is not.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (write_through && wr_en && (wr_addr == rd_addr)) rd_data <= wr_data;
      else                                                rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/dcfifo.sv
// Single-clock FIFO with the dcfifo interface: pointer, count and flag logic
// around a dual-port register array; normal or show-ahead read mode.
module dcfifo
  import dcfifo_pkg::*;
#(
  parameter int    lpm_width               = 36,
  parameter int    lpm_numwords            = 4,
  parameter int    lpm_widthu              = 2,
  parameter string lpm_showahead           = "OFF",
  parameter string overflow_checking       = "ON",
  parameter string underflow_checking      = "ON",
  parameter string intended_device_family  = "Cyclone V",
  parameter string lpm_type                = "dcfifo",
  parameter string clocks_are_synchronized = "TRUE",
  parameter int    rdsync_delaypipe        = 0,
  parameter int    wrsync_delaypipe        = 0,
  parameter string use_eab                 = "ON"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [lpm_width-1:0]  data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [lpm_width-1:0]  q,
  output logic                  rdempty,
  output logic                  wrempty,
  output logic                  rdfull,
  output logic                  wrfull,
  output logic [lpm_widthu-1:0] rdusedw,
  output logic [lpm_widthu-1:0] wrusedw
);

  localparam bit SHOW_AHEAD = (lpm_showahead == "ON");
  localparam logic [lpm_widthu-1:0] LAST = lpm_widthu'(lpm_numwords - 1);
  localparam logic [lpm_widthu-1:0] ONE  = lpm_widthu'(1);

  // Compatibility parameters are only range-checked; protection is always on.
  localparam bit PARAMS_OK =
    (lpm_numwords >= 2) && ((1 << lpm_widthu) == lpm_numwords) &&
    (lpm_showahead == "ON" || lpm_showahead == "OFF") &&
    (overflow_checking == "ON" || overflow_checking == "OFF") &&
    (underflow_checking == "ON" || underflow_checking == "OFF") &&
    (intended_device_family != "") && (lpm_type != "") &&
    (clocks_are_synchronized != "") && (use_eab != "") &&
    (rdsync_delaypipe >= 0) && (wrsync_delaypipe >= 0);

  if (!PARAMS_OK) begin : g_bad_params
    $error("dcfifo: inconsistent parameters (lpm_numwords/lpm_widthu/mode strings)");
  end

  logic [lpm_widthu-1:0] wr_ptr, rd_ptr, rd_ptr_next, usedw_r;
  logic                  empty_r, full_r;
  logic                  wr_acc, rd_acc;
  logic                  ram_rd_en;

  assign rd_acc      = !reset && rdreq && !empty_r;
  assign wr_acc      = !reset && wrreq && (!full_r || rd_acc);
  assign rd_ptr_next = rd_acc ? rd_ptr + 1'b1 : rd_ptr;

  // Show-ahead keeps the read register loaded with the post-edge head word.
  assign ram_rd_en = SHOW_AHEAD ? (rd_acc || wr_acc) : rd_acc;

  dcfifo_ram #(
    .width        (lpm_width),
    .depth        (lpm_numwords),
    .addr_w       (lpm_widthu),
    .write_through(SHOW_AHEAD)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr),
    .wr_data(data),
    .rd_en  (ram_rd_en),
    .rd_addr(SHOW_AHEAD ? rd_ptr_next : rd_ptr),
    .rd_data(q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usedw_r <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_next;
      // usedw wraps to 0 at full; full_r disambiguates it from empty.
      unique case (fifo_op(wr_acc, rd_acc))
        OP_WR: begin
          usedw_r <= usedw_r + 1'b1;
          empty_r <= 1'b0;
          full_r  <= (usedw_r == LAST);
        end
        OP_RD: begin
          usedw_r <= usedw_r - 1'b1;
          full_r  <= 1'b0;
          empty_r <= (usedw_r == ONE);
        end
        default: ;
      endcase
    end
  end

  assign rdempty = empty_r;
  assign wrempty = empty_r;
  assign rdfull  = full_r;
  assign wrfull  = full_r;
  assign rdusedw = usedw_r;
  assign wrusedw = usedw_r;

endmodule

// File: tb/tb_dcfifo.sv
// Scoreboard bench for dcfifo: one normal-mode and one show-ahead instance
// driven with the same directed stimulus and checked against a queue model.
module tb_dcfifo;

  logic        clk = 1'b0;
  logic        reset, wrreq, rdreq;
  logic [35:0] data;

  logic [35:0] q_n, q_s;
  logic        rdempty_n, wrempty_n, rdfull_n, wrfull_n;
  logic        rdempty_s, wrempty_s, rdfull_s, wrfull_s;
  logic [1:0]  rdusedw_n, wrusedw_n, rdusedw_s, wrusedw_s;

  always #5 clk = ~clk;

  dcfifo #(.lpm_width(36), .lpm_numwords(4), .lpm_widthu(2), .lpm_showahead("OFF")) dut_n (
    .clk(clk), .reset(reset), .data(data), .wrreq(wrreq), .rdreq(rdreq), .q(q_n),
    .rdempty(rdempty_n), .wrempty(wrempty_n), .rdfull(rdfull_n), .wrfull(wrfull_n),
    .rdusedw(rdusedw_n), .wrusedw(wrusedw_n)
  );

  dcfifo #(.lpm_width(36), .lpm_numwords(4), .lpm_widthu(2), .lpm_showahead("ON")) dut_s (
    .clk(clk), .reset(reset), .data(data), .wrreq(wrreq), .rdreq(rdreq), .q(q_s),
    .rdempty(rdempty_s), .wrempty(wrempty_s), .rdfull(rdfull_s), .wrfull(wrfull_s),
    .rdusedw(rdusedw_s), .wrusedw(wrusedw_s)
  );

  logic [35:0] model[$];
  logic [35:0] exp_q[$];
  logic [35:0] last_q = '0;
  logic [35:0] mon_e;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    logic       e = (model.size() == 0);
    logic       f = (model.size() == 4);
    logic [1:0] u = 2'(model.size());
    chk("empty_n", {rdempty_n, wrempty_n}, {e, e});
    chk("full_n",  {rdfull_n, wrfull_n},   {f, f});
    chk("usedw_n", {rdusedw_n, wrusedw_n}, {u, u});
    chk("empty_s", {rdempty_s, wrempty_s}, {e, e});
    chk("full_s",  {rdfull_s, wrfull_s},   {f, f});
    chk("usedw_s", {rdusedw_s, wrusedw_s}, {u, u});
  endtask

  // Apply one clock of stimulus; the model decides acceptance on its own.
  task automatic cycle(input logic w, input logic [35:0] d, input logic r);
    logic        rd_ok, wr_ok;
    logic [35:0] h;
    wrreq = w; data = d; rdreq = r;
    @(posedge clk);
    rd_ok = r && (model.size() > 0);
    wr_ok = w && ((model.size() < 4) || rd_ok);
    if (rd_ok) begin
      h = model.pop_front();
      exp_q.push_back(h);
    end
    if (wr_ok) model.push_back(d);
    @(negedge clk);
    check_flags();
    wrreq = 1'b0; rdreq = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 36'h0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; wrreq = 1'b1; rdreq = 1'b1; data = 36'hF_FFFFFFFF;
    @(posedge clk);
    model.delete();
    exp_q.delete();
    last_q = '0;
    @(negedge clk);
    check_flags();
    chk("q_n_reset", q_n, 36'h0);
    chk("q_s_reset", q_s, 36'h0);
    reset = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
  endtask

  // Monitor: normal-mode q against accepted reads, show-ahead q against the head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("q_normal", q_n, mon_e);
      last_q = mon_e;
    end else begin
      chk("q_hold", q_n, last_q);
    end
    if (model.size() > 0) chk("q_showahead", q_s, model[0]);
  end

  initial begin
    reset = 1'b1; wrreq = 1'b0; rdreq = 1'b0; data = '0;
    do_reset();

    // Fill to full, then an extra write that must be dropped.
    cycle(1'b1, 36'h1_0000000, 1'b0);
    cycle(1'b1, 36'h2_0000001, 1'b0);
    cycle(1'b1, 36'h3_0000002, 1'b0);
    cycle(1'b1, 36'h4_0000003, 1'b0);
    chk("full_after_4", {rdfull_n, rdusedw_n, rdempty_n}, {1'b1, 2'd0, 1'b0});
    cycle(1'b1, 36'h5_0000004, 1'b0);

    // Drain with single read pulses and idle gaps.
    cycle(1'b0, 36'h0, 1'b1); idle(2);
    cycle(1'b0, 36'h0, 1'b1); cycle(1'b0, 36'h0, 1'b1); idle(1);
    cycle(1'b0, 36'h0, 1'b1); idle(1);
    chk("empty_after_4_reads", rdempty_n, 1'b1);

    // Read while empty.
    cycle(1'b0, 36'h0, 1'b1); idle(1);

    // Simultaneous at count 2, then fill, then simultaneous at full.
    cycle(1'b1, 36'h0_0000011, 1'b0);
    cycle(1'b1, 36'h0_0000012, 1'b0);
    cycle(1'b1, 36'h0_0000013, 1'b1);
    cycle(1'b1, 36'h0_0000014, 1'b0);
    cycle(1'b1, 36'h0_0000015, 1'b0);
    cycle(1'b1, 36'h0_0000016, 1'b1);
    repeat (4) begin
      cycle(1'b0, 36'h0, 1'b1); idle(1);
    end

    // Simultaneous at empty, then at count 1.
    cycle(1'b1, 36'h0_0000021, 1'b1);
    cycle(1'b1, 36'h0_0000022, 1'b1);
    cycle(1'b0, 36'h0, 1'b1); idle(1);

    // Show-ahead presentation of a single word.
    cycle(1'b1, 36'h0_000000A, 1'b0); idle(2);
    cycle(1'b0, 36'h0, 1'b1); idle(1);

    // Reset with three words stored, then fresh traffic.
    cycle(1'b1, 36'h0_0000031, 1'b0);
    cycle(1'b1, 36'h0_0000032, 1'b0);
    cycle(1'b1, 36'h0_0000033, 1'b0);
    do_reset();
    cycle(1'b1, 36'h0_0000041, 1'b0);
    cycle(1'b0, 36'h0, 1'b1); idle(2);

    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
